mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store access unit between the execute stage and the data memory. It consumes the MemRead/MemWrite request that the main controller decodes, plus address, store data and funct3. It then runs a req/ack transaction on a variable-latency memory bus and holds the pipeline with `stall` until the access completes. Load data is returned sign- or zero-extended. Misaligned accesses and bus timeouts are reported as one-cycle error pulses.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum number of cycles in WAIT without `mem_ack` before the access is aborted. Legal range is 1..65535.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `MemRead` in 1: load request from the controller.
- `MemWrite` in 1: store request from the controller.
- `addr` in 32: byte address from the ALU.
- `wr_data` in 32: store data (rs2).
- `funct3` in 3: access size and sign. 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU. All other codes are illegal.
- `stall` out 1: pipeline hold. Combinational.
- `rd_data` out 32: extended load result. Registered.
- `misalign` out 1: one-cycle error pulse for a misaligned access or an illegal funct3.
- `timeout` out 1: one-cycle error pulse when the bus does not answer within `TIMEOUT`.
- `mem_req` out 1: bus request.
- `mem_we` out 1: bus write enable.
- `mem_addr` out 32: word-aligned bus address (`addr[31:2]`, 2'b00).
- `mem_wdata` out 32: lane-replicated store data.
- `mem_be` out 4: byte enables.
- `mem_ack` in 1: one-cycle completion strobe from memory.
- `mem_rdata` in 32: read word. Valid only in the cycle `mem_ack` is high.

## Operation
- **States:** IDLE, WAIT, DONE, ERR.
- **IDLE**
  - A request exists when `MemRead|MemWrite` is high. If both are high, the access is a write and the read is ignored.
  - Legal request: latch `mem_we`, `mem_addr`, `mem_wdata`, `mem_be`, `funct3[2]` and `addr[1:0]`, then go to WAIT.
  - Misaligned request or illegal funct3: go to ERR. No bus activity.
- **Alignment rules**
  - Halfword requires `addr[0]=0`.
  - Word requires `addr[1:0]=00`.
  - Byte is always aligned.
- **Byte enables**
  - Byte: 4'b0001 << `addr[1:0]`.
  - Half: 4'b0011 << `addr[1:0]`.
  - Word: 4'b1111.
- **Store data replication:** bytes go to all four lanes, halves go to both halves, words are unchanged.
- **WAIT**
  - `mem_req=1`. All bus outputs are held stable.
  - A cycle counter starts at 0 and increments every cycle.
  - `mem_ack` sampled high: capture the extended load result into `rd_data` (reads only; writes leave `rd_data` unchanged), then go to DONE.
  - Counter reaches `TIMEOUT-1` without ack: set `rd_data=0`, raise `timeout`, go to DONE.
  - If ack and timeout occur in the same cycle, ack wins.
- **Load extraction**
  - Select the lane using the latched `addr[1:0]`.
  - Sign-extend when `funct3[2]=0`, zero-extend when it is 1.
- **DONE:** `stall=0`, `mem_req=0`, `rd_data` valid. The pipeline advances this cycle. Go to IDLE unconditionally, ignoring inputs so the same instruction does not restart.
- **ERR:** `stall=0`, `misalign=1`, `rd_data=0`. Go to IDLE unconditionally.
- **`stall`** is high when (IDLE and legal request) or WAIT. Otherwise it is low.
- **Reset values:** state IDLE. `mem_req`, `mem_we`, `mem_be`, `misalign` and `timeout` are 0. `mem_addr`, `mem_wdata` and `rd_data` are 0. `stall` is 0 while `rst_n` is low.
- **Reset during WAIT:** `mem_req` drops asynchronously. The memory tolerates an abandoned request.

## Timing
- A request presented in IDLE at cycle N gives:
  - `stall` high combinationally in cycle N.
  - `mem_req` high from N+1.
- Earliest ack is at N+1, giving DONE (and `rd_data` valid, `stall` low) at N+2. A legal access therefore holds the pipeline for 2 cycles minimum.
- Ack at N+k gives DONE at N+k+1.
- A timeout pulses at cycle N+1+TIMEOUT, which is the DONE cycle.
- A misaligned access reaches ERR at N+1: 1 cycle of occupancy, no stall.
- Back-to-back accesses: a new request is accepted in the IDLE cycle after DONE/ERR, at the earliest N+3.
- `mem_ack` outside WAIT is ignored.

## Test plan
- **LW:** `addr=0x100`, funct3=010, memory acks after 3 cycles with `0xDEADBEEF`.
  - `mem_addr=0x100`, `mem_be=1111`.
  - `stall` high for 4 cycles.
  - `rd_data=0xDEADBEEF` in DONE.
- **LB and LBU:** `addr=0x103`, `mem_rdata=0x80FF_0000`.
  - LB gives `rd_data=0xFFFFFF80` with `mem_be=1000`.
  - LBU at the same address gives `0x00000080`.
- **SH:** `addr=0x202`, `wr_data=0x1234ABCD`.
  - `mem_we=1`, `mem_be=1100`, `mem_wdata=0xABCDABCD`, `mem_addr=0x200`.
  - `rd_data` unchanged.
- **Misaligned LW:** `addr=0x102`.
  - No `mem_req`.
  - `misalign` pulses 1 cycle after the request, `stall` never high, `rd_data=0`.
- **Timeout:** `TIMEOUT=4`, no ack.
  - `mem_req` high for exactly 4 cycles.
  - `timeout` pulses, `rd_data=0`, then IDLE.
- **Reset mid-WAIT, then back-to-back accesses:** assert `rst_n=0` during WAIT.
  - `mem_req` and `stall` fall immediately, all outputs return to 0.
  - After release, two consecutive LWs each complete with the correct data and no double issue.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store access unit: turns MemRead/MemWrite into a req/ack bus transaction,
// stalls the pipeline until completion, and returns extended load data.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  input  logic [2:0]  funct3,
  output logic        stall,
  output logic [31:0] rd_data,
  output logic        misalign,
  output logic        timeout,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE, ERR} state_t;

  state_t      state, state_nxt;
  logic        req, f3_ok, aligned, legal;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [15:0] cnt;
  logic        uns_q, to_q;
  logic [1:0]  size_q, lane_q;
  logic        to_hit;
  logic [31:0] shifted, load_ext;

  always_comb begin
    req       = MemRead | MemWrite;
    f3_ok     = (funct3[1:0] != 2'b11) && !(funct3[2] && funct3[1]);
    aligned   = 1'b0;
    be_nxt    = '0;
    wdata_nxt = wr_data;
    case (funct3[1:0])
      2'b00: begin
        aligned   = 1'b1;
        be_nxt    = 4'b0001 << addr[1:0];
        wdata_nxt = {4{wr_data[7:0]}};
      end
      2'b01: begin
        aligned   = ~addr[0];
        be_nxt    = 4'b0011 << addr[1:0];
        wdata_nxt = {2{wr_data[15:0]}};
      end
      2'b10: begin
        aligned = (addr[1:0] == 2'b00);
        be_nxt  = 4'b1111;
      end
      default: aligned = 1'b0;
    endcase
    legal = req && f3_ok && aligned;
  end

  always_comb begin
    shifted = mem_rdata >> {lane_q, 3'b000};
    case (size_q)
      2'b00:   load_ext = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  assign to_hit = !mem_ack && (cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = legal ? WAIT : ERR;
      WAIT:    if (mem_ack || to_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // stall is gated by rst_n so a request held across reset cannot raise it.
  always_comb begin
    mem_req  = (state == WAIT);
    misalign = (state == ERR);
    timeout  = (state == DONE) && to_q;
    stall    = rst_n && (((state == IDLE) && legal) || (state == WAIT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      rd_data   <= '0;
      cnt       <= '0;
      uns_q     <= 1'b0;
      size_q    <= '0;
      lane_q    <= '0;
      to_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (legal) begin
            mem_we    <= MemWrite;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_wdata <= wdata_nxt;
            mem_be    <= be_nxt;
            uns_q     <= funct3[2];
            size_q    <= funct3[1:0];
            lane_q    <= addr[1:0];
            cnt       <= '0;
            to_q      <= 1'b0;
          end else if (req) begin
            rd_data <= '0;
          end
        end
        WAIT: begin
          cnt <= cnt + 16'd1;
          if (mem_ack) begin
            if (!mem_we) rd_data <= load_ext;
          end else if (to_hit) begin
            rd_data <= '0;
            to_q    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed table, reset/back-to-back
// sequence, and random accesses predicted by an arithmetic reference model.
module tb_mem_access_unit;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemRead, MemWrite;
  logic [31:0] addr, wr_data;
  logic [2:0]  funct3;
  logic        stall, misalign, timeout, mem_req, mem_we, mem_ack;
  logic [31:0] rd_data, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
    .addr(addr), .wr_data(wr_data), .funct3(funct3), .stall(stall),
    .rd_data(rd_data), .misalign(misalign), .timeout(timeout),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model_rd;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [2:0]  f3;
    int          k;      // ack cycle after acceptance; 0 or >TO means no ack
    logic [31:0] rdat;
    bit          legal;
    logic [3:0]  be;
    logic [31:0] mw;
    logic [31:0] rdx;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t predict(input vec_t v, input logic [31:0] prev);
    int nb;
    logic [31:0] val, mask;
    nb = (v.f3[1:0] == 2'd0) ? 1 : (v.f3[1:0] == 2'd1) ? 2 : 4;
    v.legal = (v.f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) && (v.a % nb == 0);
    v.be = 4'(((1 << nb) - 1) << v.a[1:0]);
    v.mw = (nb == 1) ? {4{v.wd[7:0]}} : (nb == 2) ? {2{v.wd[15:0]}} : v.wd;
    mask = (nb == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nb)) - 32'd1;
    val = (v.rdat >> (8 * v.a[1:0])) & mask;
    if (!v.f3[2] && nb < 4 && val[8 * nb - 1]) val = val | ~mask;
    if (!v.legal)                v.rdx = '0;
    else if (v.k < 1 || v.k > TO) v.rdx = '0;
    else if (v.wr)               v.rdx = prev;
    else                         v.rdx = val;
    return v;
  endfunction

  // Called just after a rising edge; plays the memory side and ends in the
  // cycle after DONE/ERR so the next call is a back-to-back request.
  task automatic run_access(input vec_t v);
    bit acked;
    MemRead = v.rd; MemWrite = v.wr; addr = v.a; wr_data = v.wd; funct3 = v.f3;
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    @(negedge clk);
    chk("stall_on_request", stall, v.legal);
    chk("req_in_idle", mem_req, 0);
    chk("timeout_idle", timeout, 0);
    chk("misalign_idle", misalign, 0);
    @(posedge clk); #1;
    MemRead = 0; MemWrite = 0; addr = $urandom; wr_data = $urandom; funct3 = 3'($urandom);
    if (!v.legal) begin
      mem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("err_misalign", misalign, 1);
      chk("err_no_req", mem_req, 0);
      chk("err_no_stall", stall, 0);
      chk("err_rd_data", rd_data, v.rdx);
      chk("err_timeout", timeout, 0);
      @(posedge clk); #1;
      mem_ack = 0;
    end else begin
      acked = 0;
      for (int i = 1; i <= int'(TO); i++) begin
        acked = (i == v.k);
        mem_ack = acked; mem_rdata = acked ? v.rdat : $urandom;
        @(negedge clk);
        chk("wait_req", mem_req, 1);
        chk("wait_stall", stall, 1);
        chk("wait_we", mem_we, v.wr);
        chk("wait_addr", mem_addr, v.a & 32'hFFFF_FFFC);
        chk("wait_be", mem_be, v.be);
        chk("wait_wdata", mem_wdata, v.mw);
        @(posedge clk); #1;
        mem_ack = 0; mem_rdata = $urandom;
        if (acked) break;
      end
      @(negedge clk);
      chk("done_stall", stall, 0);
      chk("done_req", mem_req, 0);
      chk("done_timeout", timeout, !acked);
      chk("done_rd_data", rd_data, v.rdx);
      @(posedge clk); #1;
    end
    model_rd = v.rdx;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    tbl[0]  = '{1, 0, 32'h100, 32'h0,        3'b010, 3, 32'hDEADBEEF, 1, 4'hF, 32'h0,        32'hDEADBEEF};
    tbl[1]  = '{1, 0, 32'h103, 32'h0,        3'b000, 1, 32'h80FF0000, 1, 4'h8, 32'h0,        32'hFFFFFF80};
    tbl[2]  = '{1, 0, 32'h103, 32'h0,        3'b100, 2, 32'h80FF0000, 1, 4'h8, 32'h0,        32'h00000080};
    tbl[3]  = '{0, 1, 32'h202, 32'h1234ABCD, 3'b001, 2, 32'h0,        1, 4'hC, 32'hABCDABCD, 32'h00000080};
    tbl[4]  = '{1, 0, 32'h102, 32'h0,        3'b010, 1, 32'h0,        0, 4'h0, 32'h0,        32'h0};
    tbl[5]  = '{1, 0, 32'h104, 32'h11111111, 3'b010, 0, 32'h0,        1, 4'hF, 32'h11111111, 32'h0};
    tbl[6]  = '{1, 0, 32'h106, 32'h0,        3'b001, 4, 32'h80011234, 1, 4'hC, 32'h0,        32'hFFFF8001};
    tbl[7]  = '{1, 0, 32'h106, 32'h0,        3'b101, 2, 32'h80011234, 1, 4'hC, 32'h0,        32'h00008001};
    tbl[8]  = '{0, 1, 32'h101, 32'h000000A5, 3'b000, 1, 32'h0,        1, 4'h2, 32'hA5A5A5A5, 32'h00008001};
    tbl[9]  = '{1, 0, 32'h000, 32'h0,        3'b011, 1, 32'h0,        0, 4'h0, 32'h0,        32'h0};
    tbl[10] = '{1, 1, 32'h300, 32'hCAFEF00D, 3'b010, 2, 32'h0,        1, 4'hF, 32'hCAFEF00D, 32'h0};
    tbl[11] = '{1, 0, 32'h101, 32'h0,        3'b001, 1, 32'h0,        0, 4'h0, 32'h0,        32'h0};

    rst_n = 0; MemRead = 1; MemWrite = 0; addr = 32'h100; wr_data = 0; funct3 = 3'b010;
    mem_ack = 0; mem_rdata = 0; model_rd = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_timeout", timeout, 0);
    MemRead = 0;
    rst_n = 1;
    @(posedge clk); #1;

    foreach (tbl[i]) run_access(tbl[i]);

    // Reset while WAIT is in progress, then two back-to-back loads.
    MemRead = 1; addr = 32'h400; funct3 = 3'b010; wr_data = 32'h5555AAAA;
    @(posedge clk); #1;
    MemRead = 0;
    @(posedge clk); #1;
    chk("midwait_req_before", mem_req, 1);
    MemRead = 1;
    rst_n = 0;
    #1;
    chk("midwait_req_drop", mem_req, 0);
    chk("midwait_stall_drop", stall, 0);
    chk("midwait_addr", mem_addr, 0);
    chk("midwait_be", mem_be, 0);
    chk("midwait_rd_data", rd_data, 0);
    MemRead = 0;
    @(negedge clk);
    rst_n = 1;
    model_rd = 0;
    @(posedge clk); #1;
    v = '{1, 0, 32'h500, 32'h0, 3'b010, 1, 32'h01234567, 0, 4'h0, 32'h0, 32'h0};
    run_access(predict(v, model_rd));
    v = '{1, 0, 32'h504, 32'h0, 3'b010, 2, 32'h89ABCDEF, 0, 4'h0, 32'h0, 32'h0};
    run_access(predict(v, model_rd));
    @(negedge clk);
    chk("b2b_no_reissue_req", mem_req, 0);
    chk("b2b_no_reissue_stall", stall, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_idle_req", mem_req, 0);
    chk("b2b_rd_hold", rd_data, 32'h89ABCDEF);
    @(posedge clk); #1;

    for (int n = 0; n < 60; n++) begin
      int r;
      r = int'($urandom_range(0, 2));
      v.rd = (r != 1);
      v.wr = (r != 0);
      v.f3 = v.wr ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      v.a = $urandom;
      v.wd = $urandom;
      v.k = int'($urandom_range(0, TO + 1));
      v.rdat = $urandom;
      run_access(predict(v, model_rd));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
